// File: rtl/delay_code_calibrator_if.sv
// Handshake/status bundle between the delay-code calibrator and DDCB control.
// Master side drives start and the phase-detector bit; slave side is the calibrator.
interface delay_code_calibrator_if #(
  parameter int Nmbr_cascades = 4
);
  localparam int CW = $clog2(2*Nmbr_cascades+1);

  logic                       start;
  logic                       pd_late;
  logic [2*Nmbr_cascades-1:0] select;
  logic [CW-1:0]              code;
  logic                       busy;
  logic                       locked;
  logic                       cal_fail;

  modport master (output start, pd_late, input select, code, busy, locked, cal_fail);
  modport slave  (input start, pd_late, output select, code, busy, locked, cal_fail);
endinterface

// File: rtl/delay_code_calibrator.sv
// Closed-loop delay-code sweep: finds the first code whose delayed edge votes late.
// Optional lock tracking is enabled by defining DDCB_CAL_TRACK_EN.
module dcc_stage_sel #(
  parameter int CW = 4,
  parameter int K  = 0
) (
  input  logic [CW-1:0] code,
  output logic [1:0]    sel
);
  // Stage fed by depth K from the line's end: full once code covers 2K+2 units.
  localparam logic [CW-1:0] FULL = CW'(2*K+2);
  localparam logic [CW-1:0] HALF = CW'(2*K+1);

  always_comb begin
    sel = 2'b00;
    if (code >= FULL)      sel = 2'b10;
    else if (code == HALF) sel = 2'b01;
  end
endmodule

module delay_code_calibrator #(
  parameter int Nmbr_cascades = 4,
  parameter int SETTLE_CYCLES = 4,
  parameter int VOTE_SAMPLES  = 8,
  parameter int TRACK_PERIOD  = 64
) (
  input logic                    clk,
  input logic                    rst_n,
  delay_code_calibrator_if.slave cal
);
  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, VOTE, DECIDE, LOCKED, FAIL} state_t;

  localparam int N   = Nmbr_cascades;
  localparam int CW  = $clog2(2*N+1);
  localparam int SCW = $clog2(SETTLE_CYCLES+1);
  localparam int VIW = $clog2(VOTE_SAMPLES);
  localparam int LCW = $clog2(VOTE_SAMPLES)+1;
  localparam logic [CW-1:0]  CODE_MAX    = CW'(2*N);
  localparam logic [SCW-1:0] SETTLE_LAST = SCW'(SETTLE_CYCLES-1);
  localparam logic [VIW-1:0] VOTE_LAST   = VIW'(VOTE_SAMPLES-1);
  localparam logic [LCW-1:0] LATE_MAJ    = LCW'(VOTE_SAMPLES/2);
`ifdef DDCB_CAL_TRACK_EN
  localparam int TCW = $clog2(TRACK_PERIOD)+1;
  localparam logic [TCW-1:0] TRACK_LAST = TCW'(TRACK_PERIOD-1);
  localparam logic [LCW-1:0] LATE_HI    = LCW'(3*VOTE_SAMPLES/4);
  localparam logic [LCW-1:0] LATE_LO    = LCW'(VOTE_SAMPLES/4);
`endif

  state_t              state_q, state_n;
  logic [CW-1:0]       code_q, code_n;
  logic [N-1:0][1:0]   sel_q, sel_n;
  logic                busy_q, busy_n, locked_q, locked_n, fail_q, fail_n;
  logic [SCW-1:0]      settle_q, settle_n;
  logic [VIW-1:0]      vote_q, vote_n;
  logic [LCW-1:0]      late_q, late_n;
`ifdef DDCB_CAL_TRACK_EN
  logic                trk_q, trk_n;
  logic [TCW-1:0]      tcnt_q, tcnt_n;
`endif

  // select is a registered image of the next code, so it moves on the same edge as code.
  for (genvar g = 0; g < N; g++) begin : g_stage
    dcc_stage_sel #(.CW(CW), .K(N-1-g)) u_sel (.code(code_n), .sel(sel_n[g]));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      code_q   <= '0;
      sel_q    <= '0;
      busy_q   <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
      settle_q <= '0;
      vote_q   <= '0;
      late_q   <= '0;
`ifdef DDCB_CAL_TRACK_EN
      trk_q    <= 1'b0;
      tcnt_q   <= '0;
`endif
    end else begin
      state_q  <= state_n;
      code_q   <= code_n;
      sel_q    <= sel_n;
      busy_q   <= busy_n;
      locked_q <= locked_n;
      fail_q   <= fail_n;
      settle_q <= settle_n;
      vote_q   <= vote_n;
      late_q   <= late_n;
`ifdef DDCB_CAL_TRACK_EN
      trk_q    <= trk_n;
      tcnt_q   <= tcnt_n;
`endif
    end
  end

  always_comb begin
    logic restart_ok;
    state_n  = state_q;
    code_n   = code_q;
    busy_n   = busy_q;
    locked_n = locked_q;
    fail_n   = fail_q;
    settle_n = settle_q;
    vote_n   = vote_q;
    late_n   = late_q;
    restart_ok = (state_q == IDLE) || (state_q == LOCKED) || (state_q == FAIL);
`ifdef DDCB_CAL_TRACK_EN
    trk_n  = trk_q;
    tcnt_n = tcnt_q;
    restart_ok = restart_ok || trk_q;
`endif
    case (state_q)
      APPLY: begin
        settle_n = '0;
        vote_n   = '0;
        late_n   = '0;
        state_n  = SETTLE;
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          settle_n = '0;
          state_n  = VOTE;
        end else begin
          settle_n = settle_q + 1'b1;
        end
      end
      VOTE: begin
        late_n = late_q + LCW'(cal.pd_late);
        if (vote_q == VOTE_LAST) begin
          vote_n  = '0;
          state_n = DECIDE;
        end else begin
          vote_n = vote_q + 1'b1;
        end
      end
      DECIDE: begin
`ifdef DDCB_CAL_TRACK_EN
        if (trk_q) begin
          if (late_q >= LATE_HI && code_q != '0)           code_n = code_q - 1'b1;
          else if (late_q <= LATE_LO && code_q != CODE_MAX) code_n = code_q + 1'b1;
          trk_n   = 1'b0;
          tcnt_n  = '0;
          state_n = LOCKED;
        end else
`endif
        // A tie in the vote is deliberately treated as not late.
        if (late_q > LATE_MAJ) begin
          busy_n = 1'b0;
          if (code_q == '0) begin
            fail_n  = 1'b1;
            state_n = FAIL;
          end else begin
            locked_n = 1'b1;
            state_n  = LOCKED;
          end
        end else if (code_q == CODE_MAX) begin
          busy_n  = 1'b0;
          fail_n  = 1'b1;
          state_n = FAIL;
        end else begin
          code_n  = code_q + 1'b1;
          state_n = APPLY;
        end
      end
`ifdef DDCB_CAL_TRACK_EN
      LOCKED: begin
        if (tcnt_q == TRACK_LAST) begin
          tcnt_n   = '0;
          trk_n    = 1'b1;
          settle_n = '0;
          vote_n   = '0;
          late_n   = '0;
          state_n  = SETTLE;
        end else begin
          tcnt_n = tcnt_q + 1'b1;
        end
      end
`endif
      default: ;
    endcase
    if (cal.start && restart_ok) begin
      code_n   = '0;
      busy_n   = 1'b1;
      locked_n = 1'b0;
      fail_n   = 1'b0;
      state_n  = APPLY;
`ifdef DDCB_CAL_TRACK_EN
      trk_n    = 1'b0;
      tcnt_n   = '0;
`endif
    end
  end

  assign cal.code     = code_q;
  assign cal.select   = sel_q;
  assign cal.busy     = busy_q;
  assign cal.locked   = locked_q;
  assign cal.cal_fail = fail_q;
endmodule

// File: tb/tb_delay_code_calibrator.sv
// Randomised bench for delay_code_calibrator: a sweep-level model predicts every cycle's outputs.
// Define DDCB_CAL_TRACK_EN to check the lock-tracking variant.
module tb_delay_code_calibrator;
  localparam int N = 4, S = 4, V = 8, TP = 64;
  localparam int EVAL = 1 + S + V + 1;
  localparam int MAXC = 2*N;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  delay_code_calibrator_if #(.Nmbr_cascades(N)) cal();
  delay_code_calibrator #(.Nmbr_cascades(N), .SETTLE_CYCLES(S), .VOTE_SAMPLES(V),
                          .TRACK_PERIOD(TP)) dut (.clk(clk), .rst_n(rst_n), .cal(cal));

  int checks = 0, errors = 0;
  logic [V-1:0] pat [0:MAXC];
  bit exp_on = 1'b0;
  int exp_code = 0;
  bit exp_busy = 1'b0, exp_locked = 1'b0, exp_fail = 1'b0;

  // Stage fed at depth k from the end gets min(2, max(0, d-2k)) units.
  function automatic logic [2*N-1:0] ref_sel(input int d);
    logic [2*N-1:0] s = '0;
    for (int k = 0; k < N; k++) begin
      int u = d - 2*k;
      if (u < 0) u = 0;
      if (u > 2) u = 2;
      s[2*(N-1-k) +: 2] = 2'(u);
    end
    return s;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", name, act, act, req, req, $time);
    end
  endtask

  always @(negedge clk) if (exp_on) begin
    chk("code",     int'(cal.code),     exp_code);
    chk("select",   int'(cal.select),   int'(ref_sel(exp_code)));
    chk("busy",     int'(cal.busy),     int'(exp_busy));
    chk("locked",   int'(cal.locked),   int'(exp_locked));
    chk("cal_fail", int'(cal.cal_fail), int'(exp_fail));
  end

  // Drive cycles 0..to-1 after the start edge; votes come from pat only inside VOTE windows.
  task automatic drive_cycles(input int to, input int n, input int fcode, input bit flk,
                              input bit ffl, input int start_at, output int busy_cyc);
    busy_cyc = 0;
    exp_on = 1'b1;
    for (int c = 0; c < to; c++) begin
      int p = c % EVAL;
      cal.start = (c == start_at);
      if (c < n*EVAL) begin
        exp_code = c / EVAL; exp_busy = 1'b1; exp_locked = 1'b0; exp_fail = 1'b0;
      end else begin
        exp_code = fcode; exp_busy = 1'b0; exp_locked = flk; exp_fail = ffl;
      end
      if (c < n*EVAL && p >= 1+S && p < 1+S+V) cal.pd_late = pat[c/EVAL][p-1-S];
      else cal.pd_late = 1'($urandom);
      @(negedge clk);
      if (cal.busy) busy_cyc++;
      @(posedge clk); #1;
    end
    cal.start = 1'b0;
  endtask

  task automatic run_sweep(output int busy_cyc);
    int n = MAXC + 1, fcode = MAXC;
    bit flk = 1'b0, ffl = 1'b1;
    for (int d = 0; d <= MAXC; d++) begin
      if ($countones(pat[d]) > V/2) begin
        n = d + 1; fcode = d; flk = (d > 0); ffl = (d == 0);
        break;
      end
    end
    @(posedge clk); #1 cal.start = 1'b1;
    @(posedge clk); #1 cal.start = 1'b0;
    drive_cycles(n*EVAL + 3, n, fcode, flk, ffl, -1, busy_cyc);
  endtask

  initial begin
    int bc, th;
    rst_n = 1'b0; cal.start = 1'b0; cal.pd_late = 1'b0;
    #1;
    chk("rst_code", int'(cal.code), 0);
    chk("rst_select", int'(cal.select), 0);
    chk("rst_busy", int'(cal.busy), 0);
    chk("rst_locked", int'(cal.locked), 0);
    chk("rst_fail", int'(cal.cal_fail), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    exp_on = 1'b1;
    repeat (3) @(posedge clk);

    // Delay line judged late from code 5 upward.
    for (int d = 0; d <= MAXC; d++) pat[d] = (d >= 5) ? '1 : '0;
    run_sweep(bc);
    chk("lock5_code", int'(cal.code), 5);
    chk("lock5_select", int'(cal.select), 'hA4);
    chk("lock5_locked", int'(cal.locked), 1);
    chk("lock5_busy_cycles", bc, 6*14);

    // Line now judged late from code 4, pd_late constantly high.
    exp_on = 1'b0;
    cal.pd_late = 1'b1;
    repeat (TP + EVAL + 11) @(posedge clk);
    #1;
`ifdef DDCB_CAL_TRACK_EN
    chk("track_code", int'(cal.code), 4);
    chk("track_select", int'(cal.select), 'hA0);
`else
    chk("static_code", int'(cal.code), 5);
    chk("static_select", int'(cal.select), 'hA4);
`endif
    chk("track_locked", int'(cal.locked), 1);
    chk("track_busy", int'(cal.busy), 0);

    for (int d = 0; d <= MAXC; d++) pat[d] = '1;
    run_sweep(bc);
    chk("late0_fail", int'(cal.cal_fail), 1);
    chk("late0_code", int'(cal.code), 0);
    chk("late0_select", int'(cal.select), 0);
    chk("late0_locked", int'(cal.locked), 0);

    for (int d = 0; d <= MAXC; d++) pat[d] = '0;
    run_sweep(bc);
    chk("never_fail", int'(cal.cal_fail), 1);
    chk("never_code", int'(cal.code), 8);
    chk("never_select", int'(cal.select), 'hAA);

    for (int d = 0; d <= MAXC; d++) pat[d] = 8'h55;
    run_sweep(bc);
    chk("tie_fail", int'(cal.cal_fail), 1);
    chk("tie_code", int'(cal.code), 8);

    pat[3] = 8'h57;
    run_sweep(bc);
    chk("maj5_code", int'(cal.code), 3);
    chk("maj5_locked", int'(cal.locked), 1);

    for (int it = 0; it < 8; it++) begin
      th = $urandom_range(0, MAXC + 1);
      for (int d = 0; d <= MAXC; d++) begin
        if (it[0]) pat[d] = V'($urandom);
        else pat[d] = ((d >= th) ? '1 : '0) ^ V'($urandom & $urandom & $urandom);
      end
      run_sweep(bc);
    end

    // Reset during SETTLE of code 3, after a start pulse sent while busy.
    for (int d = 0; d <= MAXC; d++) pat[d] = '0;
    @(posedge clk); #1 cal.start = 1'b1;
    @(posedge clk); #1 cal.start = 1'b0;
    drive_cycles(3*EVAL + 2, MAXC + 1, MAXC, 1'b0, 1'b1, 20, bc);
    exp_on = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("arst_code", int'(cal.code), 0);
    chk("arst_select", int'(cal.select), 0);
    chk("arst_busy", int'(cal.busy), 0);
    chk("arst_locked", int'(cal.locked), 0);
    chk("arst_fail", int'(cal.cal_fail), 0);
    @(negedge clk) rst_n = 1'b1;
    exp_code = 0; exp_busy = 1'b0; exp_locked = 1'b0; exp_fail = 1'b0;
    exp_on = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk);
    #1 exp_on = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/delay_code_calibrator.md
Name: delay_code_calibrator

Overview:
- Closed-loop controller sitting directly upstream of the cascaded delay line; drives that line's per-stage 2-bit mux select word.
- Sweeps a delay code upward, judging each setting from a phase-detector bit that compares the delayed output with a reference edge.
- Locks on the first code at which the delayed edge is judged late.
- Exposes the locked code, the select word and status to the DDCB control logic.

Parameters:
- Nmbr_cascades, 4, number of delay stages driven; select width is 2*Nmbr_cascades.
- SETTLE_CYCLES, 4, idle cycles after each code change before sampling (>=1).
- VOTE_SAMPLES, 8, phase-detector samples per decision; power of two, >=4.
- TRACK_PERIOD, 64, LOCKED cycles between tracking re-evaluations (used only with the optional feature).

Ports:
- clk  input  1  system clock.
- rst_n  input  1  reset.
- start  input  1  single-cycle calibration request.
- pd_late  input  1  phase detector, already synchronous to clk; 1 = delayed edge later than reference.
- select  output  2*Nmbr_cascades  mux select word to the delay line; stage g uses bits [2g+1:2g].
- code  output  CW=$clog2(2*Nmbr_cascades+1)  current delay code, range 0..2*Nmbr_cascades.
- busy  output  1  calibration in progress.
- locked  output  1  valid code found.
- cal_fail  output  1  no valid code exists in range.

Behaviour:
- Clocking and reset: one clock, clk. rst_n is asynchronous, active-low.
- Reset values: code=0, select=0, busy=0, locked=0, cal_fail=0, state=IDLE, all counters 0.
- Stage encoding: 2'b00 = bypass (0 units), 2'b01 = 1 buffer, 2'b10 = 2 buffers. 2'b11 is never driven.
- Code-to-select mapping:
  - A bypass at stage g discards all earlier stages, so stages fill from the last stage backwards.
  - For code d, stage Nmbr_cascades-1-k gets min(2, max(0, d-2k)).
  - Example, N=4: d=5 gives select 8'b10_10_01_00 = 0xA4; d=8 gives 0xAA.
- select and code are both registered and change on the same clock edge. select is never combinationally derived from inputs.
- FSM states: IDLE, APPLY, SETTLE, VOTE, DECIDE, LOCKED, FAIL.
- IDLE:
  - On start: code<=0, busy<=1, locked<=0, cal_fail<=0, go to APPLY.
- APPLY (1 cycle):
  - select updated from code.
  - settle counter and late counter cleared.
  - Go to SETTLE.
- SETTLE: count SETTLE_CYCLES cycles, then go to VOTE.
- VOTE:
  - Sample pd_late on VOTE_SAMPLES consecutive cycles.
  - late_cnt counts the ones; its width holds VOTE_SAMPLES.
- DECIDE (1 cycle):
  - late = (late_cnt > VOTE_SAMPLES/2). An exact tie counts as not late.
  - late and code==0: go to FAIL.
  - late and code>0: go to LOCKED.
  - not late and code<2N: code<=code+1, go to APPLY.
  - not late and code==2N: go to FAIL; code stays 2N.
- Cycles per code evaluation: 1 + SETTLE_CYCLES + VOTE_SAMPLES + 1.
- LOCKED: busy=0, locked=1; code and select held.
- FAIL: busy=0, cal_fail=1; code and select held.
- start handling:
  - Ignored while busy=1.
  - In LOCKED or FAIL, start restarts the sweep from code 0 and clears both status flags.
- Status outputs are registered. locked and cal_fail are mutually exclusive.
- Reset asserted mid-sweep: all outputs return to reset values immediately (asynchronous). After release the block waits in IDLE for start.

Optional Feature:
- Macro: DDCB_CAL_TRACK_EN
- Defined:
  - In LOCKED, a TRACK_PERIOD counter runs.
  - On expiry, re-vote without leaving the locked condition: locked stays 1 and busy stays 0. This is one SETTLE pass followed by one VOTE pass.
  - late_cnt >= 3*VOTE_SAMPLES/4 and code>0: code-1.
  - late_cnt <= VOTE_SAMPLES/4 and code<2N: code+1.
  - Otherwise hold. Saturation at either bound also holds.
  - select follows the new code on the same edge. The counter then restarts.
- Undefined: LOCKED is fully static; no tracking counter or logic is present.

Test Plan:
- N=4, SETTLE=4, VOTE=8, pd_late modelled as (code>=5), pulse start -> locked=1, code=5, select=0xA4. busy falls exactly 6*14 cycles after the APPLY of code 0.
- pd_late held 1, start -> cal_fail=1 after first decision, code=0, select=0x00, locked=0.
- pd_late held 0, start -> cal_fail=1 with code=8, select=0xAA. Intermediate codes step 0..8, with select following the mapping at each step.
- pd_late high on exactly 4 of 8 vote samples at every code -> treated as not late; sweep reaches FAIL at code 8.
- Assert rst_n low during the SETTLE of code 3 -> all outputs are 0 without a clock edge. A start pulse sent while busy, before the reset, is ignored.
- With DDCB_CAL_TRACK_EN, after lock at 5, model changes to (code>=4) with pd_late constant 1 -> after TRACK_PERIOD plus one evaluation, code=4 and select=0xA0, locked stays 1. Without the macro, code stays 5.
